// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the PCIe register/BRAM access arbiter.
package mem_arb_pkg;

   // Arbiter sequencing: wait for a request, push one write, or walk one read.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } arb_state_t;

   // Requester indices, as carried by the grant and the owner register.
   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   // Fixed read latency of the BAR access block.
   localparam int DEFAULT_RD_LAT = 2;

   // Address bits [13:12] pick the BAR region behind the target port.
   localparam logic [1:0] REGION_BAR0 = 2'b01;
   localparam logic [1:0] REGION_BAR2 = 2'b10;

   // True when the region decodes to real storage; the other regions read as 0.
   function automatic logic is_mapped(input logic [1:0] region);
      return (region == REGION_BAR0) || (region == REGION_BAR2);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that was not served last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   // Pick the winner; grant is meaningless while any_req is low.
   always_comb begin
      grant   = P0;
      any_req = |req;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = P1;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single read/write port of the BAR0/BAR2 access block between the
// PCIe completer MMIO engine (p0) and the local configuration master (p1).
// One transaction is outstanding at a time; writes are posted, reads return
// the captured target data to the owning requester after RD_LAT cycles.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int RD_LAT = DEFAULT_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              p0_req_valid,
   input  logic              p0_req_we,
   input  logic [3:0]        p0_req_be,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_req_ready,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_data,

   input  logic              p1_req_valid,
   input  logic              p1_req_we,
   input  logic [3:0]        p1_req_be,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_req_ready,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_data,

   output logic [3:0]        mem_rd_be,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_be,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic              mem_wr_busy,

   output logic              busy
);

   // The response register is loaded on the edge that closes count RD_LAT-1,
   // so the pulse is visible in the cycle where the count reads RD_LAT, which
   // is also the last READ cycle.
   localparam logic [2:0] LAT_CAPTURE = 3'(RD_LAT - 1);
   localparam logic [2:0] LAT_LAST    = 3'(RD_LAT);

   arb_state_t        state;
   logic              last_grant;
   logic              hold_owner;
   logic [3:0]        hold_be;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [2:0]        lat_cnt;

   logic              grant;
   logic              any_req;
   logic              accept;
   logic              sel_we;
   logic [3:0]        sel_be;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req        ({p1_req_valid, p0_req_valid}),
      .last_grant (last_grant),
      .grant      (grant),
      .any_req    (any_req)
   );

   // Acceptance is only possible from IDLE and is held off while in reset so
   // every output reads 0 during reset.
   assign accept       = (state == IDLE) && any_req && rst_n;
   assign p0_req_ready = accept && (grant == P0);
   assign p1_req_ready = accept && (grant == P1);

   assign sel_we    = (grant == P1) ? p1_req_we    : p0_req_we;
   assign sel_be    = (grant == P1) ? p1_req_be    : p0_req_be;
   assign sel_addr  = (grant == P1) ? p1_req_addr  : p0_req_addr;
   assign sel_wdata = (grant == P1) ? p1_req_wdata : p0_req_wdata;

   // The target muxes its address on wr_en, so wr_en may only rise in WRITE.
   assign mem_wr_en   = (state == WRITE) && !mem_wr_busy;
   assign mem_wr_be   = {4'b0000, hold_be};
   assign mem_wr_addr = hold_addr;
   assign mem_wr_data = hold_wdata;
   assign mem_rd_be   = hold_be;
   assign mem_rd_addr = hold_addr;
   assign busy        = (state != IDLE);

   // Transaction sequencer: capture a granted request, then issue its write or
   // count out the read latency and hand the data back to the owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= P1;
         hold_owner   <= P0;
         hold_be      <= '0;
         hold_addr    <= '0;
         hold_wdata   <= '0;
         lat_cnt      <= '0;
         p0_rsp_valid <= 1'b0;
         p0_rsp_data  <= '0;
         p1_rsp_valid <= 1'b0;
         p1_rsp_data  <= '0;
      end else begin
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  hold_owner <= grant;
                  hold_be    <= sel_be;
                  hold_addr  <= sel_addr;
                  hold_wdata <= sel_wdata;
                  last_grant <= grant;
                  lat_cnt    <= '0;
                  state      <= sel_we ? WRITE : READ;
               end
            end
            WRITE: begin
               if (!mem_wr_busy) begin
                  state <= IDLE;
               end
            end
            READ: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_cnt == LAT_CAPTURE) begin
                  if (hold_owner == P1) begin
                     p1_rsp_data  <= mem_rd_data;
                     p1_rsp_valid <= 1'b1;
                  end else begin
                     p0_rsp_data  <= mem_rd_data;
                     p0_rsp_valid <= 1'b1;
                  end
               end
               if (lat_cnt == LAT_LAST) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single read/write port of the PCIe register/BRAM access block between two requesters:
  - p0: the PCIe completer MMIO engine.
  - p1: the local adapter configuration master.
- Serializes their transactions and drives the target port's rd_*/wr_* signals.
- Holds read addresses for the target's fixed read latency, then returns the captured read data to the owning requester.
- Sits between the TLP RX/TX engines and the BAR0/BAR2 access block.

Parameters:
- ADDR_W, 14, target address width (bits [13:12] select the BAR region).
- DATA_W, 32, data width.
- RD_LAT, 2, cycles from rd_addr stable to rd_data sampled (range 1..7).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  p0 request pending; held with fields stable until p0_req_ready
- p0_req_we  in  1  1 = write, 0 = read
- p0_req_be  in  4  byte enables
- p0_req_addr  in  ADDR_W  dword address
- p0_req_wdata  in  DATA_W  write data
- p0_req_ready  out  1  request accepted this cycle
- p0_rsp_valid  out  1  one-cycle pulse: read data valid
- p0_rsp_data  out  DATA_W  read data
- p1_* : same eight signals as p0_*, for requester 1
- mem_rd_be  out  4  to target rd_be
- mem_rd_addr  out  ADDR_W  to target rd_addr
- mem_rd_data  in  DATA_W  from target rd_data
- mem_wr_en  out  1  to target wr_en
- mem_wr_be  out  8  to target wr_be; bits [7:4] always 0
- mem_wr_addr  out  ADDR_W  to target wr_addr
- mem_wr_data  out  DATA_W  to target wr_data
- mem_wr_busy  in  1  target write stall
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = 1, so p0 wins the first contention.
  - Holding registers (owner, we, be, addr, wdata) and the latency counter cleared.
- States: IDLE, WRITE, READ.
- IDLE:
  - grant = round-robin pick among asserted pN_req_valid. On simultaneous valid, the port that is not last_grant wins. A single valid wins outright.
  - pN_req_ready = (state==IDLE) && valid && grant==N. It is combinational, at most one asserted.
  - On the ready edge: capture the request into the holding registers, set last_grant=N, go to WRITE if we=1, else READ.
- WRITE:
  - mem_wr_en = !mem_wr_busy, with mem_wr_addr/be/data from the holding registers.
  - Stay in WRITE while mem_wr_busy=1.
  - The first cycle with mem_wr_busy=0 issues exactly one wr_en pulse, then go to IDLE.
  - Writes are posted: no rsp pulse.
  - be=0 is still issued.
- READ:
  - mem_wr_en=0 throughout; mandatory, because the target muxes its address on wr_en.
  - mem_rd_addr/mem_rd_be held stable from the holding registers.
  - Counter counts 0..RD_LAT. At count==RD_LAT, register mem_rd_data into pN_rsp_data of the owner and pulse pN_rsp_valid for one cycle, then go to IDLE.
  - Reads of unmapped regions (addr[13:12] = 00 or 11) return whatever the target supplies (0). No special handling.
- Outside READ: mem_rd_addr/mem_rd_be keep the last held value. mem_wr_* data/addr/be may hold, but mem_wr_en=0.
- pN_rsp_data holds its value until the next read response to that port.
- Latency, with acceptance at cycle T:
  - Write: wr_en at T+1 if not busy.
  - Read: rd_addr valid from T+1, rsp_valid at T+1+RD_LAT.
- Throughput: writes issue every 2 cycles; reads every RD_LAT+2 cycles.
- A new request is never accepted before the current one completes: one outstanding transaction.
- Fairness: alternating service under continuous contention. No starvation; worst-case wait is one transaction.
- Reset mid-operation: the transaction is aborted immediately. No wr_en, no rsp_valid. The requester sees its acceptance but no response and must re-issue.
- A requester dropping valid before ready is legal (no acceptance occurs). Changing fields while valid is a protocol violation and is undefined.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, WRITE, READ}
  - port index constants P0=0, P1=1
  - default RD_LAT
  - BAR region constants (2'b01 = BAR0 registers, 2'b10 = BAR2 BRAM)
- One sub-module, rr_arb2: 2-way round-robin picker. Inputs: req[1:0], last_grant. Outputs: grant index, any_req.

Test Plan:
- p0 write addr 0x1005, be=4'hF, data 0x0A0B0C0D, wr_busy=0 -> p0_req_ready at T; mem_wr_en=1 at T+1 only, mem_wr_be=8'h0F, mem_wr_addr=0x1005; no rsp pulse.
- p1 read addr 0x2003, target returns 0xDEADBEEF, RD_LAT=2 -> mem_rd_addr=0x2003 held T+1..T+3; mem_wr_en=0 throughout; p1_rsp_valid single pulse at T+3 with p1_rsp_data=0xDEADBEEF; p0_rsp_valid stays 0.
- p0 and p1 both valid continuously after reset, 4 reads each -> grant order p0,p1,p0,p1,...; each port gets exactly 4 rsp pulses with the correct data.
- p0 write with mem_wr_busy=1 for 3 cycles -> state stays WRITE, mem_wr_en=0 for 3 cycles, then exactly one wr_en pulse; p1 is not accepted until the write completes.
- Assert rst_n=0 at T+2 of a p1 read -> all outputs 0 asynchronously, no p1_rsp_valid; after release, the next simultaneous request is granted to p0.
- p0 read of unmapped addr 0x0004 -> p0_rsp_valid with data 0x00000000 at T+1+RD_LAT.
